lifo_arbiter: RTL and testbench

- Shares one 16-bit LIFO between `N_REQ` requesters.
- Round-robin arbitration; one stack operation granted per cycle.
- Drives the LIFO's `push`/`pop`/`data_in` from registers, samples its `data_out` after the pop read latency, and returns pop data tagged with the requester ID.
- Keeps its own occupancy count to gate pushes on full and flag pops on empty; sits between client logic and the LIFO instance.

---
 rtl/lifo_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_lifo_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lifo_arbiter.sv
// Round-robin front end that lets N_REQ clients share one 16-bit LIFO.
// Drives registered push/pop strobes and returns pop data tagged with the requester ID.
module lifo_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_op,
  input  logic [16*N_REQ-1:0]        req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [15:0]                rsp_data,
  output logic                       rsp_err,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       lifo_push,
  output logic                       lifo_pop,
  output logic [15:0]                lifo_data_in,
  input  logic [15:0]                lifo_data_out
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               push_q, push_d;
  logic               pop_q, pop_d;
  logic [15:0]        din_q, din_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [15:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    pend_id_q, pend_id_d;

  logic [N_REQ-1:0]   elig_s;
  logic [N_REQ-1:0]   grant_s;
  logic [ID_W-1:0]    gnt_id_s;
  logic               gnt_any_s;
  logic [ID_W:0]      scan_sum_s;
  logic [ID_W-1:0]    scan_idx_s;

  // A push at full is held rather than errored; nothing is eligible while a pop is in flight.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (state_q == S_IDLE && req_valid[i] && !(!req_op[i] && level_q == LVL_W'(DEPTH))) begin
        elig_s[i] = 1'b1;
      end else begin
        elig_s[i] = 1'b0;
      end
    end
  end

  always_comb begin
    grant_s    = '0;
    gnt_id_s   = '0;
    gnt_any_s  = 1'b0;
    scan_sum_s = '0;
    scan_idx_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum_s = {1'b0, rr_q} + (ID_W+1)'(k);
      if (scan_sum_s >= (ID_W+1)'(N_REQ)) begin
        scan_sum_s = scan_sum_s - (ID_W+1)'(N_REQ);
      end else begin
        scan_sum_s = scan_sum_s;
      end
      scan_idx_s = scan_sum_s[ID_W-1:0];
      if (!gnt_any_s && elig_s[scan_idx_s]) begin
        gnt_any_s = 1'b1;
        gnt_id_s  = scan_idx_s;
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
    if (gnt_any_s) begin
      grant_s[gnt_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    level_d     = level_q;
    push_d      = 1'b0;
    pop_d       = 1'b0;
    din_d       = din_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    pend_id_d   = pend_id_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any_s) begin
          rr_d = (gnt_id_s == ID_W'(N_REQ - 1)) ? '0 : gnt_id_s + ID_W'(1);
          if (!req_op[gnt_id_s]) begin
            push_d  = 1'b1;
            din_d   = req_data[{gnt_id_s, 4'b0000} +: 16];
            level_d = level_q + LVL_W'(1);
          end else if (level_q == '0) begin
            // Empty pop answers immediately without touching the LIFO.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 16'h0000;
            rsp_id_d    = gnt_id_s;
          end else begin
            pop_d     = 1'b1;
            level_d   = level_q - LVL_W'(1);
            state_d   = S_WAIT;
            cnt_d     = '0;
            pend_id_d = gnt_id_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // First WAIT cycle is the pop strobe itself; data is valid RD_LAT cycles later.
        if (cnt_q == CNT_W'(RD_LAT)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = lifo_data_out;
          rsp_id_d    = pend_id_q;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      level_q     <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      din_q       <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      pend_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      level_q     <= level_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      pend_id_q   <= pend_id_d;
    end
  end

  assign req_ready    = grant_s;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign level        = level_q;
  assign lifo_push    = push_q;
  assign lifo_pop     = pop_q;
  assign lifo_data_in = din_q;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter with a behavioural 16-entry LIFO (one-cycle read latency).
module tb_lifo_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_op;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [4:0]  level;
  logic        lifo_push;
  logic        lifo_pop;
  logic [15:0] lifo_data_in;
  logic [15:0] lifo_data_out;

  int checks = 0;
  int errors = 0;

  lifo_arbiter #(.N_REQ(4), .DEPTH(16), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .level(level), .lifo_push(lifo_push), .lifo_pop(lifo_pop),
    .lifo_data_in(lifo_data_in), .lifo_data_out(lifo_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in LIFO: pop in cycle P, data_out valid during P+1.
  logic [15:0] mem [16];
  logic [4:0]  sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= 5'd0;
      lifo_data_out <= 16'h0000;
    end else if (lifo_push) begin
      mem[sp[3:0]] <= lifo_data_in;
      sp <= sp + 5'd1;
    end else if (lifo_pop) begin
      lifo_data_out <= mem[sp[3:0] - 4'd1];
      sp <= sp - 5'd1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b0000; req_op = 4'b0000; req_data = 64'h0;
    #12;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0 || rsp_data !== 16'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp got id %0d data %h err %b exp 0 0 0", rsp_id, rsp_data, rsp_err); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if (lifo_push !== 1'b0 || lifo_pop !== 1'b0 || lifo_data_in !== 16'h0) begin errors++; $display("FAIL rst_lifo got push %b pop %b din %h exp 0 0 0", lifo_push, lifo_pop, lifo_data_in); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_push_pair();
    req_valid = 4'b0101; req_op = 4'b0000;
    req_data = {16'h0000, 16'hB002, 16'h0000, 16'hA001};
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL pair_gnt0 got %b exp 0001", req_ready); end
    cyc();
    req_valid = 4'b0100; #1;
    checks++; if (lifo_push !== 1'b1 || lifo_data_in !== 16'hA001) begin errors++; $display("FAIL pair_push0 got push %b din %h exp 1 a001", lifo_push, lifo_data_in); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL pair_level1 got %0d exp 1", level); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL pair_gnt2 got %b exp 0100", req_ready); end
    cyc();
    req_valid = 4'b0000; #1;
    checks++; if (lifo_push !== 1'b1 || lifo_data_in !== 16'hB002) begin errors++; $display("FAIL pair_push2 got push %b din %h exp 1 b002", lifo_push, lifo_data_in); end
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL pair_level2 got %0d exp 2", level); end
    cyc();
    checks++; if (lifo_push !== 1'b0) begin errors++; $display("FAIL pair_push_end got %b exp 0", lifo_push); end
  endtask

  task automatic test_pop(input int id, input logic [15:0] exp_data, input logic [4:0] exp_lvl);
    req_valid = 4'(1 << id); req_op = 4'(1 << id); #1;
    checks++; if (req_ready !== 4'(1 << id)) begin errors++; $display("FAIL pop_gnt got %b exp %b", req_ready, 4'(1 << id)); end
    cyc();
    req_valid = 4'b0000; req_op = 4'b0000; #1;
    checks++; if (lifo_pop !== 1'b1 || lifo_push !== 1'b0) begin errors++; $display("FAIL pop_strobe got pop %b push %b exp 1 0", lifo_pop, lifo_push); end
    checks++; if (level !== exp_lvl) begin errors++; $display("FAIL pop_level got %0d exp %0d", level, exp_lvl); end
    cyc();
    checks++; if (lifo_pop !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL pop_wait got pop %b rsp %b exp 0 0", lifo_pop, rsp_valid); end
    cyc();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL pop_rsp got valid %b err %b exp 1 0", rsp_valid, rsp_err); end
    checks++; if (rsp_id !== 2'(id) || rsp_data !== exp_data) begin errors++; $display("FAIL pop_rsp_data got id %0d data %h exp %0d %h", rsp_id, rsp_data, id, exp_data); end
    cyc();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL pop_rsp_pulse got %b exp 0", rsp_valid); end
  endtask

  task automatic test_empty_pop();
    req_valid = 4'b1000; req_op = 4'b1000; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL empty_gnt got %b exp 1000", req_ready); end
    cyc();
    req_valid = 4'b0000; req_op = 4'b0000; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL empty_rsp got valid %b err %b exp 1 1", rsp_valid, rsp_err); end
    checks++; if (rsp_data !== 16'h0 || rsp_id !== 2'd3) begin errors++; $display("FAIL empty_rsp_data got data %h id %0d exp 0 3", rsp_data, rsp_id); end
    checks++; if (lifo_pop !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL empty_nopop got pop %b level %0d exp 0 0", lifo_pop, level); end
    cyc();
    checks++; if (lifo_pop !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL empty_after got pop %b rsp %b exp 0 0", lifo_pop, rsp_valid); end
  endtask

  task automatic test_rotate();
    req_valid = 4'b1111; req_op = 4'b0000;
    req_data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rot_gnt%0d got %b exp %b", k, req_ready, 4'(1 << (k % 4))); end
      if (k > 0) begin
        checks++; if (lifo_push !== 1'b1 || lifo_data_in !== 16'h1000 + 16'((k - 1) % 4)) begin errors++; $display("FAIL rot_push%0d got push %b din %h", k, lifo_push, lifo_data_in); end
      end
      cyc();
    end
    req_valid = 4'b0000; #1;
    checks++; if (lifo_push !== 1'b1 || lifo_data_in !== 16'h1003) begin errors++; $display("FAIL rot_last got push %b din %h exp 1 1003", lifo_push, lifo_data_in); end
    checks++; if (level !== 5'd8) begin errors++; $display("FAIL rot_level got %0d exp 8", level); end
    cyc();
  endtask

  task automatic test_full();
    req_valid = 4'b0001; req_op = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      req_data[15:0] = 16'hC000 + 16'(k); #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fill_gnt%0d got %b exp 0001", k, req_ready); end
      cyc();
    end
    req_data[15:0] = 16'hD00D; #1;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level got %0d exp 16", level); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_hold got %b exp 0000", req_ready); end
    cyc();
    req_valid = 4'b0011; req_op = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL full_popgnt got %b exp 0010", req_ready); end
    cyc();
    req_valid = 4'b0001; req_op = 4'b0000; #1;
    checks++; if (lifo_pop !== 1'b1 || level !== 5'd15) begin errors++; $display("FAIL full_pop got pop %b level %0d exp 1 15", lifo_pop, level); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_wait1 got %b exp 0000", req_ready); end
    cyc();
    checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin errors++; $display("FAIL full_wait2 got ready %b rsp %b exp 0000 0", req_ready, rsp_valid); end
    cyc();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'hC007 || rsp_err !== 1'b0) begin errors++; $display("FAIL full_rsp got v %b id %0d data %h err %b exp 1 1 c007 0", rsp_valid, rsp_id, rsp_data, rsp_err); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL full_regrant got %b exp 0001", req_ready); end
    cyc();
    req_valid = 4'b0000; #1;
    checks++; if (lifo_push !== 1'b1 || lifo_data_in !== 16'hD00D || level !== 5'd16) begin errors++; $display("FAIL full_push got push %b din %h level %0d exp 1 d00d 16", lifo_push, lifo_data_in, level); end
    cyc();
  endtask

  task automatic test_reset_wait();
    int seen;
    seen = 0;
    req_valid = 4'b0100; req_op = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rw_gnt got %b exp 0100", req_ready); end
    cyc();
    req_valid = 4'b0000; req_op = 4'b0000; #1;
    checks++; if (lifo_pop !== 1'b1) begin errors++; $display("FAIL rw_pop got %b exp 1", lifo_pop); end
    rst_n = 1'b0; #1;
    checks++; if (level !== 5'd0 || lifo_pop !== 1'b0 || lifo_push !== 1'b0 || lifo_data_in !== 16'h0) begin errors++; $display("FAIL rw_rst_lifo got level %0d pop %b push %b din %h exp 0", level, lifo_pop, lifo_push, lifo_data_in); end
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 16'h0 || rsp_err !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL rw_rst_rsp got v %b id %0d data %h err %b rdy %b exp 0", rsp_valid, rsp_id, rsp_data, rsp_err, req_ready); end
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rw_no_rsp got %0d pulses exp 0", seen); end
    req_valid = 4'b1000; req_op = 4'b1000; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rw_gnt3 got %b exp 1000", req_ready); end
    cyc();
    req_valid = 4'b0000; req_op = 4'b0000; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 16'h0) begin errors++; $display("FAIL rw_empty got v %b err %b id %0d data %h exp 1 1 3 0", rsp_valid, rsp_err, rsp_id, rsp_data); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_push_pair();
    test_pop(1, 16'hB002, 5'd1);
    test_pop(2, 16'hA001, 5'd0);
    test_empty_pop();
    test_rotate();
    test_full();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
